// File: rtl/sipo_sched_pkg.sv
// Shared types and sizing helpers for the round-robin deserializer scheduler.
package sipo_sched_pkg;

  localparam int WORD_W    = 4;
  localparam int BIT_CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
  import sipo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   pos;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    if (enable) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        pos = (int'(ptr) + off) % NUM_REQ;
        if (!found && req[pos]) begin
          found    = 1'b1;
          gnt[pos] = 1'b1;
          idx      = IDX_W'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/sipo_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit SIPO deserializer between requesters:
// serializes the granted word MSB-first, waits for the parallel result and
// reports it back with error/timeout status.
module sipo_rr_scheduler
  import sipo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WORD_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [WORD_W-1:0]          done_data,
  output logic                       err,
  output logic                       timeout,
  output logic                       sipo_in_valid,
  output logic                       sipo_s_in,
  input  logic                       sipo_out_valid,
  input  logic [WORD_W-1:0]          sipo_p_out
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WCNT_W = cnt_w(TIMEOUT);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [IDX_W-1:0]     cur_id, cur_id_nxt;
  logic [WORD_W-1:0]    word, word_nxt;
  logic [WORD_W-1:0]    sh, sh_nxt;
  logic [BIT_CNT_W-1:0] bcnt, bcnt_nxt;
  logic [WCNT_W-1:0]    wcnt, wcnt_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic                 done_nxt, err_nxt, timeout_nxt;
  logic                 in_valid_nxt, s_in_nxt;
  logic [IDX_W-1:0]     done_id_nxt;
  logic [WORD_W-1:0]    done_data_nxt;
  logic [WORD_W-1:0]    word_sel;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .enable (state == IDLE),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign word_sel = req_data[int'(arb_idx)*WORD_W +: WORD_W];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cur_id_nxt    = cur_id;
    word_nxt      = word;
    sh_nxt        = sh;
    bcnt_nxt      = bcnt;
    wcnt_nxt      = wcnt;
    grant_nxt     = grant;
    done_nxt      = 1'b0;
    done_id_nxt   = done_id;
    done_data_nxt = done_data;
    err_nxt       = err;
    timeout_nxt   = timeout;
    in_valid_nxt  = sipo_in_valid;
    s_in_nxt      = sipo_s_in;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = SEND;
          grant_nxt    = arb_gnt;
          cur_id_nxt   = arb_idx;
          ptr_nxt      = (int'(arb_idx) == NUM_REQ-1) ? '0 : arb_idx + IDX_W'(1);
          word_nxt     = word_sel;
          // MSB goes out on the first SEND cycle; sh keeps the remaining bits.
          sh_nxt       = {word_sel[WORD_W-2:0], 1'b0};
          bcnt_nxt     = '0;
          in_valid_nxt = 1'b1;
          s_in_nxt     = word_sel[WORD_W-1];
        end
      end
      SEND: begin
        if (bcnt == BIT_CNT_W'(WORD_W-1)) begin
          in_valid_nxt = 1'b0;
          s_in_nxt     = 1'b0;
          wcnt_nxt     = '0;
          state_nxt    = WAIT;
        end else begin
          s_in_nxt = sh[WORD_W-1];
          sh_nxt   = {sh[WORD_W-2:0], 1'b0};
          bcnt_nxt = bcnt + BIT_CNT_W'(1);
        end
      end
      WAIT: begin
        // A result on the last allowed cycle still beats the timeout.
        if (sipo_out_valid) begin
          done_data_nxt = sipo_p_out;
          err_nxt       = (sipo_p_out != word);
          timeout_nxt   = 1'b0;
          done_nxt      = 1'b1;
          done_id_nxt   = cur_id;
          state_nxt     = RESP;
        end else if (wcnt == WCNT_W'(TIMEOUT-1)) begin
          done_data_nxt = '0;
          err_nxt       = 1'b1;
          timeout_nxt   = 1'b1;
          done_nxt      = 1'b1;
          done_id_nxt   = cur_id;
          state_nxt     = RESP;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      RESP: begin
        grant_nxt     = '0;
        done_id_nxt   = '0;
        done_data_nxt = '0;
        err_nxt       = 1'b0;
        timeout_nxt   = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant         <= '0;
      done          <= 1'b0;
      done_id       <= '0;
      done_data     <= '0;
      err           <= 1'b0;
      timeout       <= 1'b0;
      sipo_in_valid <= 1'b0;
      sipo_s_in     <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      grant         <= grant_nxt;
      done          <= done_nxt;
      done_id       <= done_id_nxt;
      done_data     <= done_data_nxt;
      err           <= err_nxt;
      timeout       <= timeout_nxt;
      sipo_in_valid <= in_valid_nxt;
      sipo_s_in     <= s_in_nxt;
    end
  end

  // Datapath registers; only meaningful once the FSM has loaded them.
  always_ff @(posedge clk) begin
    cur_id <= cur_id_nxt;
    word   <= word_nxt;
    sh     <= sh_nxt;
    bcnt   <= bcnt_nxt;
    wcnt   <= wcnt_nxt;
  end

endmodule

// File: tb/tb_sipo_rr_scheduler.sv
// Bench for sipo_rr_scheduler: behavioural deserializer plus a transaction-level
// reference model of round-robin order and expected completion results.
module tb_sipo_rr_scheduler;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [4*N-1:0]   req_data;
  logic [N-1:0]     grant;
  logic             done;
  logic [1:0]       done_id;
  logic [3:0]       done_data;
  logic             err;
  logic             timeout;
  logic             sipo_in_valid;
  logic             sipo_s_in;
  logic             sipo_out_valid;
  logic [3:0]       sipo_p_out;

  sipo_rr_scheduler #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .done           (done),
    .done_id        (done_id),
    .done_data      (done_data),
    .err            (err),
    .timeout        (timeout),
    .sipo_in_valid  (sipo_in_valid),
    .sipo_s_in      (sipo_s_in),
    .sipo_out_valid (sipo_out_valid),
    .sipo_p_out     (sipo_p_out)
  );

  always #5 clk = ~clk;

  // Deserializer model: latency lat_cfg after the 4th bit (<0 = never answers),
  // result XORed with mask_cfg, optional spurious pulse mid-SEND.
  int         lat_cfg;
  logic [3:0] mask_cfg;
  logic       spur_cfg;
  logic [3:0] dsh;
  int         dnb;
  int         ddly;
  logic       darmed;
  logic [3:0] dres;

  always @(posedge clk) begin
    if (rst) begin
      sipo_out_valid <= 1'b0;
      sipo_p_out     <= 4'h0;
      dnb            <= 0;
      darmed         <= 1'b0;
      ddly           <= 0;
    end else begin
      sipo_out_valid <= 1'b0;
      if (sipo_in_valid) begin
        dsh <= {dsh[2:0], sipo_s_in};
        if (dnb == 3) begin
          dnb <= 0;
          if (lat_cfg == 0) begin
            sipo_out_valid <= 1'b1;
            sipo_p_out     <= {dsh[2:0], sipo_s_in} ^ mask_cfg;
          end else if (lat_cfg > 0) begin
            darmed <= 1'b1;
            ddly   <= lat_cfg - 1;
            dres   <= {dsh[2:0], sipo_s_in} ^ mask_cfg;
          end
        end else begin
          dnb <= dnb + 1;
          if (spur_cfg && dnb == 1) begin
            sipo_out_valid <= 1'b1;
            sipo_p_out     <= 4'hF;
          end
        end
      end
      if (darmed) begin
        if (ddly == 0) begin
          sipo_out_valid <= 1'b1;
          sipo_p_out     <= dres;
          darmed         <= 1'b0;
        end else begin
          ddly <= ddly - 1;
        end
      end
    end
  end

  int         ncmp = 0;
  int         nfail = 0;
  int         m_ptr = 0;
  logic [3:0] words [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < N; i++) req_data[4*i +: 4] = words[i];
  endtask

  // Round-robin reference: list requesters in pointer order, take the first pending.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic do_txn(input int lat, input logic [3:0] msk, input logic sp);
    int         w, c, nb, wexp;
    logic [3:0] bits, wd, edata;
    logic       eerr, etmo;
    bit         got_g, got_d;
    lat_cfg  = lat;
    mask_cfg = msk;
    spur_cfg = sp;
    w  = model_pick(req, m_ptr);
    wd = words[w];
    got_g = 1'b0;
    for (int k = 0; k < 4 && !got_g; k++) begin
      @(negedge clk);
      if (grant != '0) got_g = 1'b1;
    end
    chk("grant_seen", 32'(got_g), 32'd1);
    if (!got_g) begin
      req = '0;
      return;
    end
    chk("grant_owner", 32'(grant), 32'(1 << w));
    m_ptr = (w + 1) % N;
    c = 1; nb = 0; bits = 4'h0; got_d = 1'b0;
    while (!got_d && c < 40) begin
      if (sipo_in_valid) begin
        bits = {bits[2:0], sipo_s_in};
        nb++;
      end
      if (done) got_d = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    if (lat >= 0 && lat + 1 <= TMO) begin
      wexp  = lat + 1;
      edata = wd ^ msk;
      etmo  = 1'b0;
      eerr  = (edata != wd);
    end else begin
      wexp  = TMO;
      edata = 4'h0;
      etmo  = 1'b1;
      eerr  = 1'b1;
    end
    chk("done_seen", 32'(got_d), 32'd1);
    chk("serial_bits", 32'(bits), 32'(wd));
    chk("serial_count", 32'(nb), 32'd4);
    chk("done_latency", 32'(c), 32'(5 + wexp));
    chk("done_id", 32'(done_id), 32'(w));
    chk("done_data", 32'(done_data), 32'(edata));
    chk("err", 32'(err), 32'(eerr));
    chk("timeout", 32'(timeout), 32'(etmo));
    chk("grant_held", 32'(grant), 32'(1 << w));
    req[w] = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("grant_release", 32'(grant), 32'd0);
  endtask

  task automatic serve_all(input int lat, input logic [3:0] msk, input logic sp, input bit rnd);
    int         l;
    logic [3:0] m;
    logic       s;
    while (req != '0) begin
      l = lat; m = msk; s = sp;
      if (rnd) begin
        l = int'($urandom_range(0, 9));
        m = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        s = 1'($urandom_range(0, 1));
      end
      do_txn(l, m, s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    lat_cfg = 0; mask_cfg = 4'h0; spur_cfg = 1'b0;
    for (int i = 0; i < N; i++) words[i] = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({grant, done, done_id, done_data, err, timeout, sipo_in_valid, sipo_s_in}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_grant", 32'(grant), 32'd0);

    // Single request, echo
    words[0] = 4'b1011; load_data();
    req = 4'b0001;
    serve_all(0, 4'h0, 1'b0, 1'b0);

    // Pointer at 1: requests 0 and 2 are served 2 then 0
    words[0] = 4'h6; words[2] = 4'h9; load_data();
    req = 4'b0101;
    serve_all(0, 4'h0, 1'b0, 1'b0);

    // Abort on the 2nd SEND cycle with reset
    words[1] = 4'hA; words[3] = 4'h5; load_data();
    req = 4'b1010;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'b0010);
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("abort_outputs", 32'({grant, done, done_id, done_data, err, timeout, sipo_in_valid, sipo_s_in}), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done, grant}), 32'd0);
    end
    req = 4'b1010;
    serve_all(0, 4'h0, 1'b0, 1'b0);

    // All four together, words 1..4
    for (int i = 0; i < N; i++) words[i] = 4'(i + 1);
    load_data();
    req = 4'b1111;
    serve_all(1, 4'h0, 1'b0, 1'b0);

    // Corrupted result
    words[2] = 4'b0111; load_data();
    req = 4'b0100;
    serve_all(0, 4'b0001, 1'b0, 1'b0);

    // Silent deserializer: timeout
    words[1] = 4'hC; load_data();
    req = 4'b0010;
    serve_all(-1, 4'h0, 1'b0, 1'b0);

    // Result on final WAIT cycle beats timeout, one cycle later loses
    words[3] = 4'h3; load_data();
    req = 4'b1000;
    serve_all(7, 4'h0, 1'b0, 1'b0);
    words[0] = 4'hE; load_data();
    req = 4'b0001;
    serve_all(8, 4'h0, 1'b0, 1'b0);

    // Spurious out_valid during SEND
    words[0] = 4'h5; load_data();
    req = 4'b0001;
    serve_all(2, 4'h0, 1'b1, 1'b0);

    // Randomized request sets, words, latencies and corruption
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) words[i] = 4'($urandom);
      load_data();
      req = N'($urandom_range(1, (1 << N) - 1));
      serve_all(0, 4'h0, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
